ocp_pio_arbiter: RTL and testbench
==================================

Name: ocp_pio_arbiter

Overview:
Two-master OCP PIO arbiter that shares the single OCP slave port of the timer peripheral between two requesters (e.g. CPU PIO port and a debug/DMA master). It grants round-robin, forwards one transaction at a time to the timer, and routes the read response back to the granted master. It also rejects illegal commands and out-of-window addresses, and times out missing read responses so no master hangs.

Parameters:
WIDTH, 32, address/data width of every OCP bus
BASE_ADDR, 32'h4000_0000, base of timer register window (START +0x0, CURR +0x4, CTRL +0x8)
ADDR_SPAN, 12, window size in bytes; legal maddr = BASE_ADDR .. BASE_ADDR+ADDR_SPAN-1
TIMEOUT, 16, max cycles waiting for s_ocp_sresp on a read

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
m0_ocp_mcmd  in  4  master 0 command (0 idle, 3'b100 WRITE, 3'b010 READ)
m0_ocp_maddr  in  WIDTH  master 0 address
m0_ocp_data  in  WIDTH  master 0 write data
m0_ocp_sdata  out  WIDTH  master 0 read data
m0_ocp_sresp  out  1  master 0 response valid
m0_scmdaccept  out  1  master 0 command accepted
m0_serr  out  1  master 0 error pulse (illegal cmd/address/timeout)
m1_* (mcmd, maddr, data, sdata, sresp, scmdaccept, serr)  same as m0, for master 1
s_ocp_mcmd  out  4  command to timer
s_ocp_maddr  out  WIDTH  address to timer
s_ocp_data  out  WIDTH  write data to timer
s_ocp_sdata  in  WIDTH  read data from timer
s_ocp_sresp  in  1  timer response valid
s_scmdaccept  in  1  timer command accept
grant  out  2  one-hot current owner (debug), 0 when idle
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async): state IDLE, grant=0, last_grant=m1 (so m0 wins first tie), timeout counter 0. All outputs 0, s_ocp_mcmd=0 immediately.
- States: IDLE, CMD, RESP, ERR.
- IDLE: a master requests when its mcmd != 0. Single request is granted. With both requesting, grant the master not equal to last_grant. Grant is registered and the state moves to CMD next cycle. Arbitration latency is 1 cycle.
- CMD, legal (mcmd is WRITE/READ and maddr is in the window):
  - s_ocp_* = granted master's inputs, combinational mux.
  - On s_scmdaccept=1, the granted master's scmdaccept=1 in the same cycle.
  - WRITE: posted; go to IDLE, last_grant updated.
  - READ: go to RESP, timeout counter cleared.
- CMD, illegal: nothing is forwarded (s_ocp_mcmd stays 0). The master's scmdaccept=1 for 1 cycle; go to ERR.
- CMD, granted master drops mcmd to 0 before accept: abort, s_ocp_mcmd=0 that cycle, return to IDLE, last_grant updated.
- RESP: s_ocp_mcmd=0.
  - On s_ocp_sresp=1: granted master's sresp=1 and sdata=s_ocp_sdata for exactly that cycle (combinational). Go to IDLE, last_grant updated.
  - Counter increments each cycle. When it reaches TIMEOUT-1 without sresp, go to ERR.
  - sresp arriving in the same cycle as the last timeout count wins (normal completion).
- ERR: 1 cycle. Granted master's serr=1, sresp=1, sdata=0. Go to IDLE, last_grant updated.
- Non-granted master: all outputs 0 at all times. Its request is held pending, never dropped.
- Fairness: with both masters requesting continuously, grants alternate m0,m1,m0,…; worst-case wait is one transaction.
- Stray s_ocp_sresp/s_scmdaccept outside RESP/CMD are ignored.
- Address check is an unsigned compare on full WIDTH; no wrap-around of BASE_ADDR+ADDR_SPAN is permitted (elaboration assertion).
- Reset mid-transaction: outputs clear asynchronously, the in-flight response is discarded, and masters must reissue.

Decomposition:
- Package ocp_pio_pkg:
  - command constants OCP_IDLE=0, OCP_WRITE=3'b100, OCP_READ=3'b010
  - timer register offsets START=0x0, CURR=0x4, CTRL=0x8
  - arb_state_t enum {IDLE, CMD, RESP, ERR}
- Sub-module ocp_rr_picker: 2-way round-robin choose from req[1:0] and last_grant, purely combinational.
- Arbiter top holds the FSM, counter and muxes.

Test Plan:
- m0 WRITE 0x4000_0000 data 50, then m0 READ same address; timer returns 50 → m0_scmdaccept pulses, m0_ocp_sresp=1 with m0_ocp_sdata=50; m1 outputs stay 0.
- m0 and m1 both READ 0x4000_0008 in the same cycle, held → m0 served first, then m1. grant goes 01, 00, 10 across the two transactions; each gets its own sdata.
- Both masters issue back-to-back WRITEs for 6 transactions → grant order m0,m1,m0,m1,m0,m1; no master waits more than one transaction.
- m1 READ 0x4000_0010 (out of window), and separately mcmd=4'b0001 → s_ocp_mcmd stays 0; m1_scmdaccept=1, then m1_serr=1, m1_ocp_sresp=1, sdata=0.
- m0 READ CURR, timer never asserts sresp, TIMEOUT=16 → m0_serr pulses 16 cycles after entering RESP; the next pending m1 request is granted afterwards.
- reset asserted while in RESP → all outputs 0 asynchronously. After release, an m1-only request is granted and a simultaneous m0/m1 request grants m0 first.

Source files
------------

// File: rtl/ocp_pio_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ocp_pio_pkg
// Shared definitions for the two-master OCP PIO arbiter in front of the
// timer peripheral.
//   - OCP command encodings carried on the 4-bit mcmd fields
//   - byte offsets of the timer registers inside its window
//   - arbiter FSM state type
// ---------------------------------------------------------------------------
package ocp_pio_pkg;

  // OCP command encodings; every other non-zero code is treated as illegal.
  localparam logic [3:0] OCP_IDLE  = 4'b0000;
  localparam logic [3:0] OCP_WRITE = 4'b0100;
  localparam logic [3:0] OCP_READ  = 4'b0010;

  // Timer register byte offsets relative to the window base.
  localparam logic [31:0] REG_START = 32'h0;
  localparam logic [31:0] REG_CURR  = 32'h4;
  localparam logic [31:0] REG_CTRL  = 32'h8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/ocp_pio_arbiter_if.sv
// ---------------------------------------------------------------------------
// ocp_pio_if
// One OCP PIO link: command/address/write data flowing from a master, and
// read data, response valid, command accept and error flowing back.
//   master modport : drives mcmd/maddr/data, receives sdata/sresp/scmdaccept/serr
//   slave  modport : receives mcmd/maddr/data, drives sdata/sresp/scmdaccept/serr
// The timer side of the arbiter has no error line; its serr is simply unused.
// ---------------------------------------------------------------------------
interface ocp_pio_if #(
  parameter int WIDTH = 32
);
  import ocp_pio_pkg::*;

  logic [3:0]       mcmd;
  logic [WIDTH-1:0] maddr;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] sdata;
  logic             sresp;
  logic             scmdaccept;
  logic             serr;

  modport master (
    output mcmd, maddr, data,
    input  sdata, sresp, scmdaccept, serr
  );

  modport slave (
    input  mcmd, maddr, data,
    output sdata, sresp, scmdaccept, serr
  );

endinterface

// File: rtl/ocp_pio_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// ocp_rr_picker
// Purely combinational two-way round-robin choice.
//   req        in  2  request vector, bit 0 = master 0, bit 1 = master 1
//   last_grant in  1  index of the master served most recently
//   pick       out 2  one-hot winner, 0 when nobody requests
// ---------------------------------------------------------------------------
module ocp_rr_picker
  import ocp_pio_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] pick
);

  // On a tie the master that was not served last wins, which makes the
  // grants alternate when both masters keep requesting.
  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last_grant ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/ocp_pio_arbiter.sv
// ---------------------------------------------------------------------------
// ocp_pio_arbiter
// Shares the single OCP slave port of the timer between two masters.
// Grants round-robin, forwards one transaction at a time, routes the read
// response back to its owner, rejects illegal commands / out-of-window
// addresses and times out reads the timer never answers.
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-high reset
//   m0, m1      slave-side OCP links towards the two masters
//   s           master-side OCP link towards the timer
//   grant  out  one-hot current owner, 0 while idle
//   busy   out  high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module ocp_pio_arbiter
  import ocp_pio_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] BASE_ADDR = 32'h4000_0000,
  parameter int               ADDR_SPAN = 12,
  parameter int               TIMEOUT   = 16
) (
  input  logic       clk,
  input  logic       reset,
  ocp_pio_if.slave   m0,
  ocp_pio_if.slave   m1,
  ocp_pio_if.master  s,
  output logic [1:0] grant,
  output logic       busy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // One bit wider than the bus so the exclusive end of the window can be
  // represented even when the window touches the top of the address space.
  localparam logic [WIDTH:0] WINDOW_END = {1'b0, BASE_ADDR} + (WIDTH+1)'(ADDR_SPAN);
  localparam logic [WIDTH:0] ADDR_LIMIT = {1'b1, {WIDTH{1'b0}}};

  if ((WINDOW_END > ADDR_LIMIT) || (ADDR_SPAN < 1) || (TIMEOUT < 1)) begin : g_bad_params
    $error("ocp_pio_arbiter: address window wraps or ADDR_SPAN/TIMEOUT is zero");
  end

  arb_state_t       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [1:0]       req;
  logic [1:0]       pick;
  logic             sel;
  logic [3:0]       g_mcmd;
  logic [WIDTH-1:0] g_maddr;
  logic [WIDTH-1:0] g_data;
  logic             cmd_ok;
  logic             addr_ok;
  logic             legal;

  logic [3:0]       fwd_mcmd;
  logic [WIDTH-1:0] fwd_maddr;
  logic [WIDTH-1:0] fwd_data;
  logic [WIDTH-1:0] rsp_sdata;
  logic             rsp_sresp;
  logic             rsp_accept;
  logic             rsp_serr;

  assign req = {(m1.mcmd != OCP_IDLE), (m0.mcmd != OCP_IDLE)};

  ocp_rr_picker u_picker (
    .req        (req),
    .last_grant (last_q),
    .pick       (pick)
  );

  // Inputs of whichever master currently owns the timer.
  assign sel     = grant_q[1];
  assign g_mcmd  = sel ? m1.mcmd  : m0.mcmd;
  assign g_maddr = sel ? m1.maddr : m0.maddr;
  assign g_data  = sel ? m1.data  : m0.data;

  assign cmd_ok  = (g_mcmd == OCP_WRITE) || (g_mcmd == OCP_READ);
  assign addr_ok = (g_maddr >= BASE_ADDR) && ({1'b0, g_maddr} < WINDOW_END);
  assign legal   = cmd_ok && addr_ok;

  // State, owner, round-robin pointer and timeout counter. Reset leaves
  // last_grant pointing at master 1 so master 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  // Next-state logic plus the forwarded command and the response presented
  // to the owner. Every exit back to idle drops the grant and records the
  // owner as last served so the other master gets the next tie.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    count_d    = count_q;
    fwd_mcmd   = OCP_IDLE;
    fwd_maddr  = '0;
    fwd_data   = '0;
    rsp_sdata  = '0;
    rsp_sresp  = 1'b0;
    rsp_accept = 1'b0;
    rsp_serr   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          grant_d = pick;
          state_d = ST_CMD;
        end
      end

      ST_CMD: begin
        if (g_mcmd == OCP_IDLE) begin
          state_d = ST_IDLE;
          grant_d = 2'b00;
          last_d  = sel;
        end else if (legal) begin
          fwd_mcmd  = g_mcmd;
          fwd_maddr = g_maddr;
          fwd_data  = g_data;
          if (s.scmdaccept) begin
            rsp_accept = 1'b1;
            if (g_mcmd == OCP_READ) begin
              state_d = ST_RESP;
              count_d = '0;
            end else begin
              state_d = ST_IDLE;
              grant_d = 2'b00;
              last_d  = sel;
            end
          end
        end else begin
          // Illegal command: accept it locally so the master moves on, and
          // report the error on the following cycle.
          rsp_accept = 1'b1;
          state_d    = ST_ERR;
        end
      end

      ST_RESP: begin
        // A response on the final count still completes normally.
        if (s.sresp) begin
          rsp_sresp = 1'b1;
          rsp_sdata = s.sdata;
          state_d   = ST_IDLE;
          grant_d   = 2'b00;
          last_d    = sel;
        end else if (count_q == CNT_LAST) begin
          state_d = ST_ERR;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      ST_ERR: begin
        rsp_serr  = 1'b1;
        rsp_sresp = 1'b1;
        state_d   = ST_IDLE;
        grant_d   = 2'b00;
        last_d    = sel;
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  assign s.mcmd  = fwd_mcmd;
  assign s.maddr = fwd_maddr;
  assign s.data  = fwd_data;

  // grant_q is zero in idle, so neither master sees anything then, and the
  // master not granted is held at zero throughout a transaction.
  assign m0.sdata      = grant_q[0] ? rsp_sdata  : '0;
  assign m0.sresp      = grant_q[0] & rsp_sresp;
  assign m0.scmdaccept = grant_q[0] & rsp_accept;
  assign m0.serr       = grant_q[0] & rsp_serr;

  assign m1.sdata      = grant_q[1] ? rsp_sdata  : '0;
  assign m1.sresp      = grant_q[1] & rsp_sresp;
  assign m1.scmdaccept = grant_q[1] & rsp_accept;
  assign m1.serr       = grant_q[1] & rsp_serr;

  assign grant = grant_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ocp_pio_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ocp_pio_arbiter
// Directed bench for ocp_pio_arbiter. The bench plays both masters and the
// timer cycle by cycle; inputs change 1 ns after a rising edge and outputs
// are sampled 1 ns later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_ocp_pio_arbiter;
  import ocp_pio_pkg::*;

  localparam int          WIDTH = 32;
  localparam logic [31:0] BASE  = 32'h4000_0000;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] grant;
  logic       busy;

  int checks = 0;
  int errors = 0;

  ocp_pio_if #(.WIDTH(WIDTH)) m0_if ();
  ocp_pio_if #(.WIDTH(WIDTH)) m1_if ();
  ocp_pio_if #(.WIDTH(WIDTH)) s_if ();

  ocp_pio_arbiter #(
    .WIDTH     (WIDTH),
    .BASE_ADDR (BASE),
    .ADDR_SPAN (12),
    .TIMEOUT   (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .m0    (m0_if.slave),
    .m1    (m1_if.slave),
    .s     (s_if.master),
    .grant (grant),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkMaster(input int which, input string tag, input logic accept,
                             input logic resp, input logic err, input logic [31:0] rdata);
    if (which == 0) begin
      checkOutput({tag, "_m0_flags"}, {29'b0, m0_if.scmdaccept, m0_if.sresp, m0_if.serr},
                  {29'b0, accept, resp, err});
      checkOutput({tag, "_m0_sdata"}, m0_if.sdata, rdata);
    end else begin
      checkOutput({tag, "_m1_flags"}, {29'b0, m1_if.scmdaccept, m1_if.sresp, m1_if.serr},
                  {29'b0, accept, resp, err});
      checkOutput({tag, "_m1_sdata"}, m1_if.sdata, rdata);
    end
  endtask

  task automatic applyStimulus(input int which, input logic [3:0] cmd,
                               input logic [31:0] addr, input logic [31:0] wdata);
    if (which == 0) begin
      m0_if.mcmd  = cmd;
      m0_if.maddr = addr;
      m0_if.data  = wdata;
    end else begin
      m1_if.mcmd  = cmd;
      m1_if.maddr = addr;
      m1_if.data  = wdata;
    end
  endtask

  task automatic setTimer(input logic accept, input logic resp, input logic [31:0] rdata);
    s_if.scmdaccept = accept;
    s_if.sresp      = resp;
    s_if.sdata      = rdata;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    int          done0;
    int          done1;
    logic [1:0]  expGrant;
    logic [31:0] expData;

    reset = 1'b1;
    applyStimulus(0, OCP_IDLE, 32'h0, 32'h0);
    applyStimulus(1, OCP_IDLE, 32'h0, 32'h0);
    setTimer(1'b0, 1'b0, 32'h0);
    s_if.serr = 1'b0;

    // Reset state
    #2;
    checkOutput("rst_grant", {30'b0, grant}, 32'h0);
    checkOutput("rst_busy", {31'b0, busy}, 32'h0);
    checkOutput("rst_s_mcmd", {28'b0, s_if.mcmd}, 32'h0);
    checkMaster(0, "rst", 1'b0, 1'b0, 1'b0, 32'h0);
    checkMaster(1, "rst", 1'b0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    reset = 1'b0;

    // m0 WRITE 50 then READ it back
    $display("[TB] m0 write/read");
    applyStimulus(0, OCP_WRITE, BASE, 32'd50);
    settle();
    checkOutput("wr_idle_grant", {30'b0, grant}, 32'h0);
    nextCycle();
    setTimer(1'b1, 1'b0, 32'h0);
    settle();
    checkOutput("wr_grant", {30'b0, grant}, 32'h1);
    checkOutput("wr_s_mcmd", {28'b0, s_if.mcmd}, {28'b0, OCP_WRITE});
    checkOutput("wr_s_maddr", s_if.maddr, BASE);
    checkOutput("wr_s_data", s_if.data, 32'd50);
    checkMaster(0, "wr_acc", 1'b1, 1'b0, 1'b0, 32'h0);
    checkMaster(1, "wr_acc", 1'b0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(0, OCP_READ, BASE, 32'h0);
    setTimer(1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("rd_idle_grant", {30'b0, grant}, 32'h0);
    nextCycle();
    setTimer(1'b1, 1'b0, 32'h0);
    settle();
    checkOutput("rd_s_mcmd", {28'b0, s_if.mcmd}, {28'b0, OCP_READ});
    checkMaster(0, "rd_acc", 1'b1, 1'b0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(0, OCP_IDLE, 32'h0, 32'h0);
    setTimer(1'b0, 1'b1, 32'd50);
    settle();
    checkOutput("rd_resp_busy", {31'b0, busy}, 32'h1);
    checkOutput("rd_resp_s_mcmd", {28'b0, s_if.mcmd}, 32'h0);
    checkMaster(0, "rd_resp", 1'b0, 1'b1, 1'b0, 32'd50);
    checkMaster(1, "rd_resp", 1'b0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    setTimer(1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("rd_done_busy", {31'b0, busy}, 32'h0);

    // Fresh reset so the pointer favours m0, then a simultaneous READ
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    $display("[TB] simultaneous reads");
    applyStimulus(0, OCP_READ, BASE + 32'h8, 32'h0);
    applyStimulus(1, OCP_READ, BASE + 32'h8, 32'h0);
    settle();
    checkOutput("tie_idle_grant", {30'b0, grant}, 32'h0);
    nextCycle();
    setTimer(1'b1, 1'b0, 32'h0);
    settle();
    checkOutput("tie_first_grant", {30'b0, grant}, 32'h1);
    checkOutput("tie_s_maddr", s_if.maddr, BASE + 32'h8);
    checkMaster(0, "tie_first_acc", 1'b1, 1'b0, 1'b0, 32'h0);
    checkMaster(1, "tie_first_acc", 1'b0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(0, OCP_IDLE, 32'h0, 32'h0);
    setTimer(1'b0, 1'b1, 32'h11);
    settle();
    checkMaster(0, "tie_first_resp", 1'b0, 1'b1, 1'b0, 32'h11);
    checkMaster(1, "tie_first_resp", 1'b0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    setTimer(1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("tie_gap_grant", {30'b0, grant}, 32'h0);
    nextCycle();
    setTimer(1'b1, 1'b0, 32'h0);
    settle();
    checkOutput("tie_second_grant", {30'b0, grant}, 32'h2);
    checkOutput("tie_second_s_mcmd", {28'b0, s_if.mcmd}, {28'b0, OCP_READ});
    checkMaster(1, "tie_second_acc", 1'b1, 1'b0, 1'b0, 32'h0);
    checkMaster(0, "tie_second_acc", 1'b0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(1, OCP_IDLE, 32'h0, 32'h0);
    setTimer(1'b0, 1'b1, 32'h22);
    settle();
    checkMaster(1, "tie_second_resp", 1'b0, 1'b1, 1'b0, 32'h22);
    checkMaster(0, "tie_second_resp", 1'b0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    setTimer(1'b0, 1'b0, 32'h0);

    // Back-to-back writes from both masters: three each, alternating
    $display("[TB] back-to-back writes");
    done0 = 0;
    done1 = 0;
    applyStimulus(0, OCP_WRITE, BASE, 32'h100);
    applyStimulus(1, OCP_WRITE, BASE + 32'h4, 32'h200);
    setTimer(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      settle();
      checkOutput($sformatf("b2b%0d_idle_grant", i), {30'b0, grant}, 32'h0);
      nextCycle();
      settle();
      expGrant = (i % 2 == 0) ? 2'b01 : 2'b10;
      expData  = (i % 2 == 0) ? 32'h100 + 32'(done0) : 32'h200 + 32'(done1);
      checkOutput($sformatf("b2b%0d_grant", i), {30'b0, grant}, {30'b0, expGrant});
      checkOutput($sformatf("b2b%0d_s_data", i), s_if.data, expData);
      checkOutput($sformatf("b2b%0d_accept", i), {30'b0, m1_if.scmdaccept, m0_if.scmdaccept},
                  {30'b0, expGrant});
      if (i % 2 == 0) done0++;
      else done1++;
      nextCycle();
      if (i % 2 == 0) begin
        if (done0 == 3) applyStimulus(0, OCP_IDLE, 32'h0, 32'h0);
        else applyStimulus(0, OCP_WRITE, BASE, 32'h100 + 32'(done0));
      end else begin
        if (done1 == 3) applyStimulus(1, OCP_IDLE, 32'h0, 32'h0);
        else applyStimulus(1, OCP_WRITE, BASE + 32'h4, 32'h200 + 32'(done1));
      end
    end
    setTimer(1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("b2b_end_busy", {31'b0, busy}, 32'h0);

    // m1 out-of-window read, then an illegal command code
    $display("[TB] illegal requests");
    applyStimulus(1, OCP_READ, BASE + 32'h10, 32'h0);
    nextCycle();
    setTimer(1'b1, 1'b0, 32'h0);
    settle();
    checkOutput("oow_grant", {30'b0, grant}, 32'h2);
    checkOutput("oow_s_mcmd", {28'b0, s_if.mcmd}, 32'h0);
    checkMaster(1, "oow_acc", 1'b1, 1'b0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(1, OCP_IDLE, 32'h0, 32'h0);
    setTimer(1'b0, 1'b1, 32'hDEAD);
    settle();
    checkOutput("oow_err_s_mcmd", {28'b0, s_if.mcmd}, 32'h0);
    checkMaster(1, "oow_err", 1'b0, 1'b1, 1'b1, 32'h0);
    checkMaster(0, "oow_err", 1'b0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    setTimer(1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("oow_done_busy", {31'b0, busy}, 32'h0);
    applyStimulus(1, 4'b0001, BASE, 32'h0);
    nextCycle();
    settle();
    checkOutput("badcmd_s_mcmd", {28'b0, s_if.mcmd}, 32'h0);
    checkMaster(1, "badcmd_acc", 1'b1, 1'b0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(1, OCP_IDLE, 32'h0, 32'h0);
    settle();
    checkMaster(1, "badcmd_err", 1'b0, 1'b1, 1'b1, 32'h0);

    // Window edges: last legal byte is forwarded, one below base is not
    nextCycle();
    applyStimulus(0, OCP_WRITE, BASE + 32'hB, 32'h5A);
    nextCycle();
    setTimer(1'b1, 1'b0, 32'h0);
    settle();
    checkOutput("top_edge_s_mcmd", {28'b0, s_if.mcmd}, {28'b0, OCP_WRITE});
    checkOutput("top_edge_s_maddr", s_if.maddr, BASE + 32'hB);
    checkMaster(0, "top_edge_acc", 1'b1, 1'b0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(0, OCP_WRITE, 32'h3FFF_FFFC, 32'h1);
    nextCycle();
    settle();
    checkOutput("low_edge_s_mcmd", {28'b0, s_if.mcmd}, 32'h0);
    checkMaster(0, "low_edge_acc", 1'b1, 1'b0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(0, OCP_IDLE, 32'h0, 32'h0);
    settle();
    checkMaster(0, "low_edge_err", 1'b0, 1'b1, 1'b1, 32'h0);
    nextCycle();
    setTimer(1'b0, 1'b0, 32'h0);

    // m0 READ CURR that the timer never answers; m1 waits behind it
    $display("[TB] read timeout");
    applyStimulus(0, OCP_READ, BASE + REG_CURR, 32'h0);
    nextCycle();
    setTimer(1'b1, 1'b0, 32'h0);
    applyStimulus(1, OCP_WRITE, BASE + REG_CTRL, 32'h7);
    settle();
    checkOutput("to_grant", {30'b0, grant}, 32'h1);
    checkMaster(0, "to_acc", 1'b1, 1'b0, 1'b0, 32'h0);
    checkMaster(1, "to_acc", 1'b0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(0, OCP_IDLE, 32'h0, 32'h0);
    setTimer(1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 16; k++) begin
      settle();
      checkOutput($sformatf("to_wait%0d", k), {28'b0, busy, grant, m0_if.serr}, 32'b1010);
      nextCycle();
    end
    settle();
    checkOutput("to_err_grant", {30'b0, grant}, 32'h1);
    checkMaster(0, "to_err", 1'b0, 1'b1, 1'b1, 32'h0);
    nextCycle();
    settle();
    checkOutput("to_after_grant", {30'b0, grant}, 32'h0);
    nextCycle();
    setTimer(1'b1, 1'b0, 32'h0);
    settle();
    checkOutput("to_next_grant", {30'b0, grant}, 32'h2);
    checkOutput("to_next_s_data", s_if.data, 32'h7);
    checkMaster(1, "to_next_acc", 1'b1, 1'b0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(1, OCP_IDLE, 32'h0, 32'h0);
    setTimer(1'b0, 1'b0, 32'h0);

    // Response on the last timeout count completes normally
    applyStimulus(0, OCP_READ, BASE + REG_CURR, 32'h0);
    nextCycle();
    setTimer(1'b1, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(0, OCP_IDLE, 32'h0, 32'h0);
    setTimer(1'b0, 1'b0, 32'h0);
    repeat (15) nextCycle();
    setTimer(1'b0, 1'b1, 32'h77);
    settle();
    checkMaster(0, "late_resp", 1'b0, 1'b1, 1'b0, 32'h77);
    nextCycle();
    setTimer(1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("late_done", {30'b0, busy, m0_if.serr}, 32'h0);

    // Reset while waiting in RESP discards the response
    $display("[TB] reset mid-transaction");
    applyStimulus(0, OCP_READ, BASE, 32'h0);
    nextCycle();
    setTimer(1'b1, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(0, OCP_IDLE, 32'h0, 32'h0);
    setTimer(1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("mid_rst_pre_busy", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    setTimer(1'b0, 1'b1, 32'h99);
    settle();
    checkOutput("mid_rst_busy", {31'b0, busy}, 32'h0);
    checkOutput("mid_rst_grant", {30'b0, grant}, 32'h0);
    checkOutput("mid_rst_s_mcmd", {28'b0, s_if.mcmd}, 32'h0);
    checkMaster(0, "mid_rst", 1'b0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    reset = 1'b0;
    setTimer(1'b0, 1'b0, 32'h0);
    applyStimulus(1, OCP_WRITE, BASE + 32'h8, 32'h3);
    nextCycle();
    setTimer(1'b1, 1'b0, 32'h0);
    settle();
    checkOutput("post_rst_m1_grant", {30'b0, grant}, 32'h2);
    checkMaster(1, "post_rst_m1", 1'b1, 1'b0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(1, OCP_IDLE, 32'h0, 32'h0);
    setTimer(1'b0, 1'b0, 32'h0);

    // Simultaneous request: m0 first, then it abandons before accept
    applyStimulus(0, OCP_WRITE, BASE, 32'h1);
    applyStimulus(1, OCP_WRITE, BASE + 32'h4, 32'h2);
    nextCycle();
    settle();
    checkOutput("post_rst_tie_grant", {30'b0, grant}, 32'h1);
    applyStimulus(0, OCP_IDLE, 32'h0, 32'h0);
    setTimer(1'b1, 1'b0, 32'h0);
    settle();
    checkOutput("abort_s_mcmd", {28'b0, s_if.mcmd}, 32'h0);
    checkMaster(0, "abort", 1'b0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    settle();
    checkOutput("abort_idle_grant", {30'b0, grant}, 32'h0);
    nextCycle();
    settle();
    checkOutput("abort_next_grant", {30'b0, grant}, 32'h2);
    checkOutput("abort_next_s_data", s_if.data, 32'h2);
    checkMaster(1, "abort_next", 1'b1, 1'b0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(1, OCP_IDLE, 32'h0, 32'h0);
    setTimer(1'b0, 1'b0, 32'h0);
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
